// File: rtl/sargantana_icache_pkg.sv
// Shared types and helpers for the Sargantana L1 I-cache data way.
// Holds the refill FSM encoding, default geometry constants and the
// per-byte even-parity helper used when parity storage is enabled.
package sargantana_icache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } fill_state_t;

    localparam int ICACHE_LINE_W = 256;
    localparam int ICACHE_DEPTH  = 128;
    localparam int ICACHE_BEAT_W = 64;

    // Widest line the parity helper accepts. Callers zero-extend narrower
    // lines and keep only the low LINE_W/8 result bits.
    localparam int PARITY_MAX_LINE_W = 2048;

    // One even-parity bit per byte: bit i is the XOR of byte i, so the byte
    // together with its parity bit always has an even number of ones.
    function automatic logic [PARITY_MAX_LINE_W/8-1:0] byte_parity(
        input logic [PARITY_MAX_LINE_W-1:0] line
    );
        logic [PARITY_MAX_LINE_W/8-1:0] par;
        par = '0;
        for (int i = 0; i < PARITY_MAX_LINE_W/8; i++) begin
            par[i] = ^line[i*8 +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/sargantana_icache_way_ram.sv
// Storage array for one I-cache way: synchronous write, combinational read.
// Latency: write lands at the clock edge; read data follows rd_addr_i in the same cycle.
// Backpressure: none; one write and one read may occur every cycle.
//
// Ports:
//   clk_i      clock, rising edge
//   wr_en_i    write enable
//   wr_addr_i  write set index
//   wr_data_i  write line (data plus any parity bits)
//   rd_addr_i  read set index
//   rd_data_o  read line
//
// The array is deliberately not reset.
module sargantana_icache_way_ram
    import sargantana_icache_pkg::*;
#(
    parameter  int WIDTH  = ICACHE_LINE_W,
    parameter  int DEPTH  = ICACHE_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/sargantana_icache_way_fill.sv
// One L1 I-cache data way with integrated refill sequencer and registered read port.
// Latency: read data one cycle after request; a refill takes N_BEATS accepted beats plus one write cycle.
// Backpressure: fill_ready_o is high only in COLLECT; beats offered at other times are not taken.
//
// Ports:
//   clk_i, rst_i           clock (rising edge) and asynchronous active-high reset
//   rd_req_i, rd_addr_i    read request and set index, accepted every cycle
//   rd_valid_o, rd_data_o  read response (data holds when no request)
//   rd_perr_o              parity error on the current read response
//   fill_start_i, fill_addr_i           start a refill of the given set (IDLE only)
//   fill_beat_valid_i, fill_beat_i      refill beats, beat 0 least significant
//   fill_ready_o           beat accepted when valid && ready
//   fill_done_o            pulse in the cycle the line is written
//   busy_o                 refill in progress
//
// Optional feature macro: SARGANTANA_ICACHE_WAY_PARITY_EN stores one even-parity
// bit per byte and reports mismatches on read; undefined ties rd_perr_o low.
module sargantana_icache_way_fill
    import sargantana_icache_pkg::*;
#(
    parameter  int LINE_W  = ICACHE_LINE_W,
    parameter  int DEPTH   = ICACHE_DEPTH,
    parameter  int BEAT_W  = ICACHE_BEAT_W,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int N_BEATS = LINE_W / BEAT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_valid_o,
    output logic [LINE_W-1:0] rd_data_o,
    output logic              rd_perr_o,
    input  logic              fill_start_i,
    input  logic [ADDR_W-1:0] fill_addr_i,
    input  logic              fill_beat_valid_i,
    input  logic [BEAT_W-1:0] fill_beat_i,
    output logic              fill_ready_o,
    output logic              fill_done_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(N_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

`ifdef SARGANTANA_ICACHE_WAY_PARITY_EN
    localparam int PAR_W = LINE_W / 8;
    localparam int RAM_W = LINE_W + PAR_W;
`else
    localparam int RAM_W = LINE_W;
`endif

    generate
        if ((LINE_W % BEAT_W) != 0 || N_BEATS < 2 || DEPTH < 2) begin : g_bad_geometry
            $error("sargantana_icache_way_fill: need LINE_W %% BEAT_W == 0, N_BEATS >= 2, DEPTH >= 2");
        end
`ifdef SARGANTANA_ICACHE_WAY_PARITY_EN
        if ((LINE_W % 8) != 0 || LINE_W > PARITY_MAX_LINE_W) begin : g_bad_parity_geometry
            $error("sargantana_icache_way_fill: parity needs whole bytes within PARITY_MAX_LINE_W");
        end
`endif
    endgenerate

    fill_state_t       state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0] fill_addr_q;
    logic [LINE_W-1:0] line_buf;

    logic              beat_acc;
    logic              ram_wr_en;
    logic [RAM_W-1:0]  ram_wr_data;
    logic [RAM_W-1:0]  ram_rd_data;
    logic              fwd_hit;

    // fill_ready_o is a registered copy of (state == COLLECT), so it can gate
    // the handshake directly.
    assign beat_acc  = fill_beat_valid_i & fill_ready_o;
    assign ram_wr_en = (state == WRITE);

    // A read in the commit cycle to the set being written sees the new line.
    assign fwd_hit = ram_wr_en & rd_req_i & (rd_addr_i == fill_addr_q);

    // ------------------------------------------------------------------
    // Refill sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            fill_addr_q  <= '0;
            line_buf     <= '0;
            fill_ready_o <= 1'b0;
            fill_done_o  <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            fill_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (fill_start_i) begin
                        fill_addr_q  <= fill_addr_i;
                        beat_cnt     <= '0;
                        state        <= COLLECT;
                        fill_ready_o <= 1'b1;
                        busy_o       <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (beat_acc) begin
                        line_buf[beat_cnt*BEAT_W +: BEAT_W] <= fill_beat_i;
                        beat_cnt <= beat_cnt + 1'b1;
                        // Leaving on the last beat keeps the counter from
                        // ever needing to wrap within a refill.
                        if (beat_cnt == LAST_BEAT) begin
                            state        <= WRITE;
                            fill_ready_o <= 1'b0;
                            fill_done_o  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    fill_ready_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage and optional parity
    // ------------------------------------------------------------------
`ifdef SARGANTANA_ICACHE_WAY_PARITY_EN
    logic [PARITY_MAX_LINE_W-1:0]   wr_line_ext;
    logic [PARITY_MAX_LINE_W-1:0]   rd_line_ext;
    logic [PARITY_MAX_LINE_W/8-1:0] wr_par_full;
    logic [PARITY_MAX_LINE_W/8-1:0] rd_par_full;
    logic                           rd_par_err;

    always_comb begin
        wr_line_ext              = '0;
        wr_line_ext[LINE_W-1:0]  = line_buf;
        rd_line_ext              = '0;
        rd_line_ext[LINE_W-1:0]  = ram_rd_data[LINE_W-1:0];
    end

    assign wr_par_full = byte_parity(wr_line_ext);
    assign rd_par_full = byte_parity(rd_line_ext);
    assign ram_wr_data = {wr_par_full[PAR_W-1:0], line_buf};
    // Forwarded data carries freshly computed parity, so it cannot mismatch.
    assign rd_par_err  = ~fwd_hit & (rd_par_full[PAR_W-1:0] != ram_rd_data[RAM_W-1:LINE_W]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_perr_o <= 1'b0;
        end else begin
            rd_perr_o <= rd_req_i & rd_par_err;
        end
    end
`else
    assign ram_wr_data = line_buf;
    assign rd_perr_o   = 1'b0;
`endif

    sargantana_icache_way_ram #(
        .WIDTH (RAM_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (fill_addr_q),
        .wr_data_i (ram_wr_data),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (ram_rd_data)
    );

    // ------------------------------------------------------------------
    // Registered read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= rd_req_i;
            if (rd_req_i) begin
                rd_data_o <= fwd_hit ? line_buf : ram_rd_data[LINE_W-1:0];
            end
        end
    end

endmodule
